// File: rtl/pwm_multi_if.sv
// Control/status bundle for pwm_multi: register writes, mode controls and PWM outputs.
// The module side uses the slave modport; whoever programs the block uses master.
interface pwm_multi_if #(
  parameter int N_BIT  = 10,
  parameter int N_CH   = 4,
  parameter int PS_BIT = 8
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic              enable;
  logic [N_BIT-1:0]  data_in;
  logic [CH_W-1:0]   ch_sel;
  logic              load;
  logic [N_BIT-1:0]  period_in;
  logic              period_load;
  logic [PS_BIT-1:0] prescale;
  logic              center;
  logic [N_CH-1:0]   pwm_out;
  logic              period_start;

  modport master (
    output enable, data_in, ch_sel, load, period_in, period_load, prescale, center,
    input  pwm_out, period_start
  );

  modport slave (
    input  enable, data_in, ch_sel, load, period_in, period_load, prescale, center,
    output pwm_out, period_start
  );
endinterface

// File: rtl/pwm_multi.sv
// Multi-channel PWM with a shared prescaled period counter, edge/center alignment
// and double-buffered duty/period registers that swap only at a period boundary.
module pwm_multi #(
  parameter int N_BIT  = 10,
  parameter int N_CH   = 4,
  parameter int PS_BIT = 8
) (
  input logic        clk,
  input logic        rst,
  pwm_multi_if.slave bus
);

  logic [PS_BIT-1:0] pre_cnt;
  logic [N_BIT-1:0]  count;
  logic [N_BIT-1:0]  count_nxt;
  logic [N_BIT-1:0]  period_act;
  logic [N_BIT-1:0]  period_pend;
  logic [N_BIT-1:0]  duty_pend [N_CH];
  logic [N_BIT-1:0]  duty_act  [N_CH];
  logic              dir_down;
  logic              dir_nxt;
  logic              mode_center;
  logic              at_start;
  logic              tick;
  logic              boundary;
  logic [N_CH-1:0]   write_hit;
  logic [N_CH-1:0]   cmp;

  assign tick     = (pre_cnt == bus.prescale);
  assign boundary = tick && (count_nxt == '0);

  // Next counter value if a tick happens; a boundary is any tick landing on 0.
  always_comb begin
    count_nxt = count;
    dir_nxt   = dir_down;
    if (!mode_center) begin
      count_nxt = (count >= period_act) ? '0 : count + 1'b1;
    end else if (period_act == '0) begin
      count_nxt = '0;
    end else if (!dir_down) begin
      if (count >= period_act) begin
        count_nxt = period_act - 1'b1;
        dir_nxt   = 1'b1;
      end else begin
        count_nxt = count + 1'b1;
      end
    end else begin
      count_nxt = count - 1'b1;
    end
  end

  always_comb begin
    write_hit = '0;
    cmp       = '0;
    for (int i = 0; i < N_CH; i++) begin
      write_hit[i] = bus.load && (int'(bus.ch_sel) == i);
      cmp[i]       = (count < duty_act[i]);
    end
  end

  // While disabled the active registers track the latest writes (including the
  // one landing this cycle) so the first enabled period uses them directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt          <= '0;
      count            <= '0;
      dir_down         <= 1'b0;
      mode_center      <= 1'b0;
      at_start         <= 1'b1;
      period_act       <= '1;
      period_pend      <= '1;
      bus.pwm_out      <= '0;
      bus.period_start <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        duty_pend[i] <= '0;
        duty_act[i]  <= '0;
      end
    end else begin
      if (bus.period_load) period_pend <= bus.period_in;
      for (int i = 0; i < N_CH; i++) begin
        if (write_hit[i]) duty_pend[i] <= bus.data_in;
      end

      if (!bus.enable) begin
        pre_cnt          <= '0;
        count            <= '0;
        dir_down         <= 1'b0;
        at_start         <= 1'b1;
        mode_center      <= bus.center;
        period_act       <= bus.period_load ? bus.period_in : period_pend;
        bus.pwm_out      <= '0;
        bus.period_start <= 1'b0;
        for (int i = 0; i < N_CH; i++) begin
          duty_act[i] <= write_hit[i] ? bus.data_in : duty_pend[i];
        end
      end else begin
        pre_cnt          <= tick ? '0 : pre_cnt + 1'b1;
        bus.pwm_out      <= cmp;
        bus.period_start <= at_start;
        at_start         <= boundary;
        if (tick) begin
          count    <= count_nxt;
          dir_down <= dir_nxt;
        end
        if (boundary) begin
          dir_down    <= 1'b0;
          mode_center <= bus.center;
          period_act  <= period_pend;
          for (int i = 0; i < N_CH; i++) begin
            duty_act[i] <= duty_pend[i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed self-checking bench for pwm_multi: each task captures output traces
// and compares them with hand-derived bit patterns (bit j = cycle j after period_start).
module tb_pwm_multi;
  localparam int N_BIT  = 10;
  localparam int N_CH   = 5;
  localparam int PS_BIT = 8;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [63:0] cap_ch [N_CH];
  logic [63:0] cap_ps;

  pwm_multi_if #(.N_BIT(N_BIT), .N_CH(N_CH), .PS_BIT(PS_BIT)) bus ();

  pwm_multi #(.N_BIT(N_BIT), .N_CH(N_CH), .PS_BIT(PS_BIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_duty(input int ch, input int val);
    bus.ch_sel  = 3'(ch);
    bus.data_in = 10'(val);
    bus.load    = 1'b1;
    step();
    bus.load    = 1'b0;
  endtask

  task automatic wr_period(input int val);
    bus.period_in   = 10'(val);
    bus.period_load = 1'b1;
    step();
    bus.period_load = 1'b0;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 5000; n++) begin
      step();
      if (bus.period_start === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Samples n cycles starting with the current one; optionally pulses a duty
  // write during cycle inj_j.
  task automatic capture(input int n, input int inj_j, input int inj_ch, input int inj_val);
    for (int c = 0; c < N_CH; c++) cap_ch[c] = '0;
    cap_ps = '0;
    for (int j = 0; j < n; j++) begin
      for (int c = 0; c < N_CH; c++) cap_ch[c][j] = bus.pwm_out[c];
      cap_ps[j] = bus.period_start;
      if (j == inj_j) begin
        bus.ch_sel  = 3'(inj_ch);
        bus.data_in = 10'(inj_val);
        bus.load    = 1'b1;
      end
      step();
      bus.load = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.enable = 1'b1;
    repeat (3) step();
    total++;
    if (bus.pwm_out !== 5'b0 || bus.period_start !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_hold: pwm_out=%b period_start=%b, want 00000/0", bus.pwm_out, bus.period_start);
    end
    rst = 1'b0;
    total++;
    if (bus.period_start !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_release_same: period_start=%b, want 0", bus.period_start);
    end
    step();
    total++;
    if (bus.period_start !== 1'b1 || bus.pwm_out !== 5'b0) begin
      bad++;
      $display("[TB] FAIL reset_first_start: period_start=%b pwm_out=%b, want 1/00000", bus.period_start, bus.pwm_out);
    end
    step();
    total++;
    if (bus.period_start !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_pulse_width: period_start=%b, want 0", bus.period_start);
    end
    bus.enable = 1'b0;
    step();
  endtask

  task automatic test_edge();
    bit ok;
    bus.enable = 1'b0;
    bus.center = 1'b0;
    bus.prescale = 8'd0;
    wr_period(9);
    wr_duty(0, 3);
    wr_duty(1, 10);
    wr_duty(2, 0);
    wr_duty(3, 9);
    wr_duty(4, 1);
    bus.enable = 1'b1;
    wait_start(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL edge_timeout: no period_start, want one");
    end
    capture(20, -1, 0, 0);
    total++;
    if (cap_ch[0][19:0] !== 20'h01C07) begin
      bad++; $display("[TB] FAIL edge_ch0: got %h want %h", cap_ch[0][19:0], 20'h01C07);
    end
    total++;
    if (cap_ch[1][19:0] !== 20'hFFFFF) begin
      bad++; $display("[TB] FAIL edge_ch1_high: got %h want %h", cap_ch[1][19:0], 20'hFFFFF);
    end
    total++;
    if (cap_ch[2][19:0] !== 20'h00000) begin
      bad++; $display("[TB] FAIL edge_ch2_low: got %h want %h", cap_ch[2][19:0], 20'h00000);
    end
    total++;
    if (cap_ch[3][19:0] !== 20'h7FDFF) begin
      bad++; $display("[TB] FAIL edge_ch3: got %h want %h", cap_ch[3][19:0], 20'h7FDFF);
    end
    total++;
    if (cap_ch[4][19:0] !== 20'h00401) begin
      bad++; $display("[TB] FAIL edge_ch4: got %h want %h", cap_ch[4][19:0], 20'h00401);
    end
    total++;
    if (cap_ps[19:0] !== 20'h00401) begin
      bad++; $display("[TB] FAIL edge_period_start: got %h want %h", cap_ps[19:0], 20'h00401);
    end
  endtask

  task automatic test_shadow();
    bit ok;
    wait_start(ok);
    capture(20, 4, 0, 7);
    total++;
    if (!ok || cap_ch[0][19:0] !== 20'h1FC07) begin
      bad++; $display("[TB] FAIL shadow_mid: ok=%0d got %h want %h", ok, cap_ch[0][19:0], 20'h1FC07);
    end
    wait_start(ok);
    capture(30, 8, 0, 2);
    total++;
    if (!ok || cap_ch[0][29:0] !== 30'h031FC7F) begin
      bad++; $display("[TB] FAIL shadow_boundary: ok=%0d got %h want %h", ok, cap_ch[0][29:0], 30'h031FC7F);
    end
  endtask

  task automatic test_center();
    bit ok;
    bus.enable = 1'b0;
    bus.center = 1'b1;
    wr_period(4);
    wr_duty(0, 2);
    wr_duty(1, 5);
    wr_duty(2, 1);
    wr_duty(3, 4);
    wr_duty(4, 0);
    bus.enable = 1'b1;
    wait_start(ok);
    capture(16, -1, 0, 0);
    total++;
    if (!ok || cap_ch[0][15:0] !== 16'h8383) begin
      bad++; $display("[TB] FAIL center_ch0: ok=%0d got %h want %h", ok, cap_ch[0][15:0], 16'h8383);
    end
    total++;
    if (cap_ch[1][15:0] !== 16'hFFFF) begin
      bad++; $display("[TB] FAIL center_ch1_high: got %h want %h", cap_ch[1][15:0], 16'hFFFF);
    end
    total++;
    if (cap_ch[2][15:0] !== 16'h0101) begin
      bad++; $display("[TB] FAIL center_ch2: got %h want %h", cap_ch[2][15:0], 16'h0101);
    end
    total++;
    if (cap_ch[3][15:0] !== 16'hEFEF) begin
      bad++; $display("[TB] FAIL center_ch3: got %h want %h", cap_ch[3][15:0], 16'hEFEF);
    end
    total++;
    if (cap_ps[15:0] !== 16'h0101) begin
      bad++; $display("[TB] FAIL center_period_start: got %h want %h", cap_ps[15:0], 16'h0101);
    end
  endtask

  task automatic test_prescaler();
    bit ok;
    bus.enable = 1'b0;
    bus.center = 1'b0;
    bus.prescale = 8'd2;
    wr_period(3);
    wr_duty(0, 1);
    wr_duty(1, 0);
    wr_duty(2, 4);
    wr_duty(3, 3);
    wr_duty(4, 2);
    wr_duty(5, 3);
    wr_duty(6, 0);
    wr_duty(7, 0);
    bus.enable = 1'b1;
    wait_start(ok);
    capture(24, -1, 0, 0);
    total++;
    if (!ok || cap_ch[0][23:0] !== 24'h007007) begin
      bad++; $display("[TB] FAIL prescale_ch0: ok=%0d got %h want %h", ok, cap_ch[0][23:0], 24'h007007);
    end
    total++;
    if (cap_ch[1][23:0] !== 24'h000000) begin
      bad++; $display("[TB] FAIL prescale_ch1: got %h want %h", cap_ch[1][23:0], 24'h000000);
    end
    total++;
    if (cap_ch[2][23:0] !== 24'hFFFFFF) begin
      bad++; $display("[TB] FAIL prescale_ch2: got %h want %h", cap_ch[2][23:0], 24'hFFFFFF);
    end
    total++;
    if (cap_ch[3][23:0] !== 24'h1FF1FF) begin
      bad++; $display("[TB] FAIL prescale_ch3: got %h want %h", cap_ch[3][23:0], 24'h1FF1FF);
    end
    total++;
    if (cap_ch[4][23:0] !== 24'h03F03F) begin
      bad++; $display("[TB] FAIL prescale_ch4: got %h want %h", cap_ch[4][23:0], 24'h03F03F);
    end
    total++;
    if (cap_ps[23:0] !== 24'h001001) begin
      bad++; $display("[TB] FAIL prescale_period_start: got %h want %h", cap_ps[23:0], 24'h001001);
    end
  endtask

  task automatic test_enable();
    bit ok;
    wait_start(ok);
    repeat (4) step();
    bus.enable = 1'b0;
    step();
    total++;
    if (!ok || bus.pwm_out !== 5'b0 || bus.period_start !== 1'b0) begin
      bad++; $display("[TB] FAIL enable_drop: ok=%0d pwm_out=%b period_start=%b, want 00000/0", ok, bus.pwm_out, bus.period_start);
    end
    repeat (3) step();
    total++;
    if (bus.pwm_out !== 5'b0) begin
      bad++; $display("[TB] FAIL enable_hold_low: pwm_out=%b, want 00000", bus.pwm_out);
    end
    bus.enable = 1'b1;
    step();
    total++;
    if (bus.period_start !== 1'b1 || bus.pwm_out !== 5'b11101) begin
      bad++; $display("[TB] FAIL enable_restart: period_start=%b pwm_out=%b, want 1/11101", bus.period_start, bus.pwm_out);
    end
    capture(12, -1, 0, 0);
    total++;
    if (cap_ch[0][11:0] !== 12'h007 || cap_ps[11:0] !== 12'h001) begin
      bad++; $display("[TB] FAIL enable_clean_period: ch0=%h ps=%h, want 007/001", cap_ch[0][11:0], cap_ps[11:0]);
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    int n;
    logic [N_CH-1:0] seen;
    bus.prescale = 8'd0;
    wait_start(ok);
    repeat (3) step();
    rst = 1'b1;
    step();
    total++;
    if (!ok || bus.pwm_out !== 5'b0 || bus.period_start !== 1'b0) begin
      bad++; $display("[TB] FAIL midreset_outputs: ok=%0d pwm_out=%b period_start=%b, want 00000/0", ok, bus.pwm_out, bus.period_start);
    end
    rst = 1'b0;
    step();
    total++;
    if (bus.period_start !== 1'b1) begin
      bad++; $display("[TB] FAIL midreset_first_start: period_start=%b, want 1", bus.period_start);
    end
    n = 0;
    seen = '0;
    do begin
      seen = seen | bus.pwm_out;
      step();
      n++;
    end while (bus.period_start !== 1'b1 && n < 3000);
    total++;
    if (n !== 1024) begin
      bad++; $display("[TB] FAIL midreset_period: interval=%0d clk, want 1024", n);
    end
    total++;
    if (seen !== 5'b0) begin
      bad++; $display("[TB] FAIL midreset_duty_cleared: pwm_out or=%b, want 00000", seen);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.data_in = '0;
    bus.ch_sel = '0;
    bus.load = 1'b0;
    bus.period_in = '0;
    bus.period_load = 1'b0;
    bus.prescale = '0;
    bus.center = 1'b0;
    test_reset();
    test_edge();
    test_shadow();
    test_center();
    test_prescaler();
    test_enable();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
